// File: rtl/mux16_if.sv
// mux16_if: word-mux bus bundle shared by mux16 and its environment.
//
// Signals (WIDTH-bit unless noted):
//   a      data word selected when sel=0
//   b      data word selected when sel=1
//   sel    1-bit select, 0 -> a, 1 -> b
//   out    combinational mux result
//   out_q  registered mux result, one-cycle latency
//   par    (MUX16_PARITY_EN only) XOR-reduction of out
//   par_q  (MUX16_PARITY_EN only) registered XOR-reduction of the selected word
//
// Handshake: there is no valid/ready pair. Every input value is consumed
// combinationally by out, and every rising clk edge with rst_n=1 is a transfer
// into out_q.
//
// Modports:
//   master  drives a/b/sel, observes the results (environment side)
//   slave   receives a/b/sel, drives the results (mux16 side)
//
// Optional feature macro: MUX16_PARITY_EN (adds par and par_q).

interface mux16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
`ifdef MUX16_PARITY_EN
  logic             par;
  logic             par_q;
`endif

  modport master (
`ifdef MUX16_PARITY_EN
    input  par,
    input  par_q,
`endif
    output a,
    output b,
    output sel,
    input  out,
    input  out_q
  );

  modport slave (
`ifdef MUX16_PARITY_EN
    output par,
    output par_q,
`endif
    input  a,
    input  b,
    input  sel,
    output out,
    output out_q
  );
endinterface

// File: rtl/mux16.sv
// mux16: two-input word multiplexer with a combinational output and a
// registered copy for timing-closed consumers.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (clears out_q and, if present, par_q)
//   bus    mux16_if.slave: a, b, sel in; out, out_q (and par, par_q) out
//
// Behaviour:
//   out   = sel ? b : a, zero latency, independent of clk and rst_n
//   out_q = value of out sampled at each rising clk while rst_n=1
//   An unknown sel drives out to all X in simulation so that neither input
//   is silently preferred.
//
// Optional feature macro: MUX16_PARITY_EN
//   defined   -> adds par (XOR of out, combinational) and par_q (registered
//                alongside out_q, cleared by reset)
//   undefined -> neither port exists; mux and out_q behave identically.
//
// There is no FSM in this block; the only state is out_q (plus par_q).

module mux16 #(
  parameter int WIDTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  mux16_if.slave  bus
);

  logic [WIDTH-1:0] sel_word;

  // A case statement rather than ?: so an X/Z select yields all-X instead of
  // merging the bits where a and b happen to agree.
  always_comb begin
    sel_word = 'x;
    case (bus.sel)
      1'b0:    sel_word = bus.a;
      1'b1:    sel_word = bus.b;
      default: sel_word = 'x;
    endcase
  end

  assign bus.out = sel_word;

  // The register samples the same word that drives out, so an input change
  // coincident with the edge is captured at its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_q <= '0;
    end else begin
      bus.out_q <= sel_word;
    end
  end

`ifdef MUX16_PARITY_EN
  assign bus.par = ^sel_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.par_q <= 1'b0;
    end else begin
      bus.par_q <= ^sel_word;
    end
  end
`endif

endmodule

// File: tb/tb_mux16.sv
// tb_mux16: directed plus randomized checks of mux16 against a word-array
// reference model. Registered expectations travel through a queue so the
// one-cycle latency of out_q is modelled explicitly.

module tb_mux16;
  localparam int W = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux16_if #(.WIDTH(W)) bus ();

  mux16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
`ifdef MUX16_PARITY_EN
  logic [W-1:0] exp_par_q[$];
`endif

  // Reference model: the two words sit in an array and sel is simply the index.
  function automatic logic [W-1:0] ref_out(logic [W-1:0] wa, logic [W-1:0] wb,
                                           logic s);
    logic [W-1:0] words [2];
    words[0] = wa;
    words[1] = wb;
    return words[s];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Apply new inputs away from the clock edge and check the combinational path.
  task automatic set_in(input logic [W-1:0] na, input logic [W-1:0] nb,
                        input logic ns);
    logic [W-1:0] e;
    bus.a   = na;
    bus.b   = nb;
    bus.sel = ns;
    #1;
    e = ref_out(na, nb, ns);
    check("out", bus.out, e);
`ifdef MUX16_PARITY_EN
    check("par", {{(W-1){1'b0}}, bus.par}, {{(W-1){1'b0}}, ^e});
`endif
  endtask

  // One rising edge: predict the captured value from the pre-edge inputs and
  // reset level, then check the registered outputs just after the edge.
  task automatic tick();
    logic [W-1:0] e;
    e = rst_n ? ref_out(bus.a, bus.b, bus.sel) : '0;
    exp_q.push_back(e);
`ifdef MUX16_PARITY_EN
    exp_par_q.push_back({{(W-1){1'b0}}, ^e});
`endif
    @(posedge clk);
    #1;
    check("out_q", bus.out_q, exp_q.pop_front());
`ifdef MUX16_PARITY_EN
    check("par_q", {{(W-1){1'b0}}, bus.par_q}, exp_par_q.pop_front());
`endif
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n   = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.sel = 1'b0;
    #1;
    check("reset_out_q", bus.out_q, '0);
`ifdef MUX16_PARITY_EN
    check("reset_par_q", {{(W-1){1'b0}}, bus.par_q}, '0);
`endif
    rst_n = 1'b1;

    // All-zero words, both selects.
    set_in(16'h0000, 16'h0000, 1'b0);
    set_in(16'h0000, 16'h0000, 1'b1);
    tick();

    // One side zero.
    set_in(16'h0000, 16'h1234, 1'b0);
    tick();
    set_in(16'h0000, 16'h1234, 1'b1);
    tick();
    set_in(16'h9876, 16'h0000, 1'b0);
    tick();
    set_in(16'h9876, 16'h0000, 1'b1);
    tick();

    // Alternating patterns with sel toggling every cycle.
    for (int i = 0; i < 8; i++) begin
      set_in(16'hAAAA, 16'h5555, i[0]);
      tick();
    end

    // Single set bit gives odd parity.
    set_in(16'h0001, 16'h0000, 1'b0);
    tick();

    // Reset mid-operation, asserted between edges.
    set_in(16'h0000, 16'h1234, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("async_reset_out_q", bus.out_q, '0);
    check("out_during_reset", bus.out, 16'h1234);
`ifdef MUX16_PARITY_EN
    check("async_reset_par_q", {{(W-1){1'b0}}, bus.par_q}, '0);
`endif
    tick();
    tick();
    set_in(16'hFFFF, 16'h1234, 1'b1);
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      set_in(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
